irq_pending_ctrl: RTL
=====================

// Module: irq_pending_ctrl
// PURPOSE
//  Interrupt front-end that sits directly upstream of the 4-input priority encoder.
//  - Detects rising edges on raw request lines and latches them as pending bits.
//  - Presents the masked pending vector to the encoder.
//  - Consumes the encoder's index/valid result.
//  - Runs a req/ack handshake with the CPU, clearing each serviced bit on ack.
// PARAMETERS
//  N_SRC   4   number of interrupt sources (encoder input width)
//  IDX_W   2   index width, = clog2(N_SRC) (encoder output width)
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  rst_n      in   1      synchronous reset, active-low
//  irq_in     in   N_SRC  raw requests, synchronous to clk, edge-sensitive
//  irq_mask   in   N_SRC  1 = source enabled
//  pend       out  N_SRC  pending & irq_mask; drives encoder input
//  enc_idx    in   IDX_W  encoder index of highest set pend bit
//  enc_valid  in   1      encoder valid (pend != 0)
//  irq_req    out  1      interrupt request to CPU
//  irq_id     out  IDX_W  source id being requested; stable while irq_req=1
//  irq_ack    in   1      CPU acknowledge, single-cycle pulse
//  busy       out  1      1 when FSM is not in IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//  - pending=0, prev_in=all-ones, state=IDLE.
//  - irq_req=0, irq_id=0, busy=0, pend=0.
//  - prev_in=all-ones: a line already high at reset release is NOT an edge.
//  Edge capture:
//  - rise = irq_in & ~prev_in; prev_in <= irq_in every cycle.
//  - pending[i] <= 1 on rise[i], independent of irq_mask.
//  - Masked bits stay pending and surface in pend when unmasked.
//  - A level held high sets pending once only.
//  Combinational output: pend = pending & irq_mask.
//  FSM, 2 states:
//  - IDLE: if enc_valid then irq_id <= enc_idx, irq_req <= 1, go REQ.
//  - REQ: irq_req=1, irq_id frozen; irq_ack ignored until REQ.
//    On irq_ack: pending[irq_id] <= 0, irq_req <= 0, go IDLE.
//  Latency:
//  - irq_in first sampled high at edge E0 -> pending set at E0.
//  - irq_req=1 after E1.
//  - ack at Ea -> irq_req=0 after Ea; next request earliest after Ea+1.
//  - irq_req is therefore low at least 1 cycle between requests.
//  Simultaneous events:
//  - rise[i] and clear of bit i in the same cycle: set wins, bit stays pending.
//  - Multiple rises in one cycle: all latched; serviced highest index first.
//  - irq_mask dropped for irq_id while in REQ: request NOT withdrawn; ack still clears.
//  - irq_ack in IDLE: no effect.
//  Reset mid-operation: any state returns to IDLE.
//  - All pending lost; irq_req=0 the cycle after the reset edge.
// TESTING
//  1. Reset, irq_in=0001 pulse 1 cycle -> irq_req=1 two edges later, irq_id=0;
//     ack -> irq_req=0, pend=0000.
//  2. irq_in=1010 same cycle -> irq_id=3 first; ack -> 1 idle cycle, then irq_id=1;
//     ack -> pend=0000.
//  3. mask=1011, pulse bit2 -> pending set, pend=0000, irq_req stays 0;
//     mask=1111 -> irq_req=1, irq_id=2.
//  4. In REQ for id 1, new rise on bit1 in the ack cycle -> pend[1] still 1;
//     second request id=1 issued.
//  5. irq_in=0100 held high 20 cycles -> exactly one request/ack cycle;
//     no retrigger after ack.
//  6. rst_n=0 while irq_req=1, pending=0110 -> next cycle irq_req=0, pend=0000.
//     irq_in held high through release -> no request.

Source files
------------

// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl: interrupt front-end ahead of an N_SRC-input priority encoder.
// It latches rising edges on the raw request lines as pending bits and shows the
// masked pending vector to the encoder. It takes the encoder result and runs a
// req/ack handshake with the CPU, clearing the serviced bit on each ack.
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous reset, active-low
//   irq_in     raw requests, edge-sensitive
//   irq_mask   per-source enable (1 = enabled)
//   pend       pending & irq_mask, combinational, feeds the encoder
//   enc_idx    encoder index of highest set pend bit
//   enc_valid  encoder valid (pend != 0)
//   irq_req    request to CPU, registered
//   irq_id     requested source id, registered, frozen while irq_req=1
//   irq_ack    CPU acknowledge, single-cycle pulse
//   busy       registered, 1 while the handshake FSM is not idle
module irq_pending_ctrl #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [N_SRC-1:0] irq_mask,
  output logic [N_SRC-1:0] pend,
  input  logic [IDX_W-1:0] enc_idx,
  input  logic             enc_valid,
  output logic             irq_req,
  output logic [IDX_W-1:0] irq_id,
  input  logic             irq_ack,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;
  logic             req_q, req_d;
  logic [IDX_W-1:0] id_q, id_d;
  logic             busy_q, busy_d;

  // Handshake FSM next-state and the clear strobe for the serviced source.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    id_d    = id_q;
    clr     = '0;
    case (state_q)
      IDLE: begin
        if (enc_valid) begin
          id_d    = enc_idx;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (irq_ack) begin
          clr     = N_SRC'(1) << id_q;
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == REQ);
  end

  // Edge capture; a new rise in the same cycle as its clear keeps the bit set.
  always_comb begin
    rise      = irq_in & ~prev_q;
    pending_d = (pending_q & ~clr) | rise;
  end

  // prev_q resets to all-ones so a line already high at release is not an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      prev_q    <= '1;
      req_q     <= 1'b0;
      id_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      prev_q    <= irq_in;
      req_q     <= req_d;
      id_q      <= id_d;
      busy_q    <= busy_d;
    end
  end

  assign pend    = pending_q & irq_mask;
  assign irq_req = req_q;
  assign irq_id  = id_q;
  assign busy    = busy_q;

endmodule
